// File: rtl/apb2_bldc_multi_ctrl.sv
// Multi-channel BLDC APB2 register block: duty ramping, sticky fault/ocw latches (W1C), strobes, slverr, irq.
// Each transfer takes setup + 2 access cycles (pready low in ACCESS only); drivers see ch_* registered, irq 1 cycle behind flags.
module apb2_bldc_multi_ctrl #(
    parameter int data_width = 32,
    parameter int addr_width = 8,
    parameter int channels   = 2,
    parameter int duty_width = 11
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [addr_width-1:0]          paddr,
    input  logic [data_width-1:0]          pwdata,
    input  logic [3:0]                     pstrb,
    input  logic [2:0]                     pprot,
    output logic [data_width-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [3*channels-1:0]          hall_values,
    input  logic [3*channels-1:0]          sector,
    input  logic [2*channels-1:0]          detected_dir,
    input  logic [channels-1:0]            hall_error,
    input  logic [channels-1:0]            fault_n,
    input  logic [channels-1:0]            overcurrent_n,
    output logic [channels-1:0]            ch_enable,
    output logic [2*channels-1:0]          ch_dir,
    output logic [duty_width*channels-1:0] ch_duty,
    output logic                           irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} apb_state_t;
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam int         CSW      = addr_width - 5;

    apb_state_t state_q, state_d;

    logic [channels-1:0]   ctrl_en_q, ctrl_en_d, irq_en_q, irq_en_d;
    logic [channels-1:0]   fault_q, fault_d, ocw_q, ocw_d;
    logic [channels-1:0]   flt_s1_q, flt_s1_d, flt_s2_q, flt_s2_d;
    logic [channels-1:0]   ocw_s1_q, ocw_s1_d, ocw_s2_q, ocw_s2_d;
    logic [channels-1:0]   en_out_q, en_out_d;
    logic                  irq_q, irq_d;
    logic [1:0]            ctrl_dir_q [channels];
    logic [1:0]            ctrl_dir_d [channels];
    logic [1:0]            ch_dir_q   [channels];
    logic [1:0]            ch_dir_d   [channels];
    logic [duty_width-1:0] target_q   [channels];
    logic [duty_width-1:0] target_d   [channels];
    logic [duty_width-1:0] actual_q   [channels];
    logic [duty_width-1:0] actual_d   [channels];
    logic [15:0]           step_q     [channels];
    logic [15:0]           step_d     [channels];
    logic [15:0]           presc_q    [channels];
    logic [15:0]           presc_d    [channels];
    logic [15:0]           pcnt_q     [channels];
    logic [15:0]           pcnt_d     [channels];

    logic [CSW-1:0]        ch_sel;
    logic [4:0]            offs;
    logic                  ch_ok, acc_err, wr_commit;
    logic [channels-1:0]   ch_hit, eff_en, tick;
    logic [duty_width-1:0] eff_tgt [channels];
    logic [31:0]           bmask, rd_word, wr_merged, w1c;
    logic                  unused_pprot;

    assign unused_pprot = ^pprot;

    always_comb begin
        ch_sel    = paddr[addr_width-1:5];
        offs      = paddr[4:0];
        ch_ok     = int'(ch_sel) < channels;
        acc_err   = !ch_ok || (offs >= 5'h18) || (offs[1:0] != 2'b00)
                    || (pwrite && (offs == 5'h00 || offs == 5'h0C));
        bmask     = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
        wr_commit = (state_q == ST_DONE) && pwrite && !acc_err;
        for (int c = 0; c < channels; c++) begin
            ch_hit[c]  = ch_ok && (int'(ch_sel) == c);
            eff_en[c]  = ctrl_en_q[c] && !fault_q[c];
            // Target is held at 0 until the applied direction matches the request.
            eff_tgt[c] = (eff_en[c] && (ctrl_dir_q[c] == ch_dir_q[c])) ? target_q[c] : '0;
            tick[c]    = (pcnt_q[c] == presc_q[c]);
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < channels; c++) begin
            if (ch_hit[c]) begin
                case (offs)
                    5'h00:   rd_word = {20'b0, (actual_q[c] != eff_tgt[c]), ocw_q[c], fault_q[c],
                                        hall_error[c], detected_dir[2*c +: 2], sector[3*c +: 3],
                                        hall_values[3*c +: 3]};
                    5'h04:   rd_word = {28'b0, irq_en_q[c], ctrl_dir_q[c], ctrl_en_q[c]};
                    5'h08:   rd_word = 32'(target_q[c]);
                    5'h0C:   rd_word = 32'(actual_q[c]);
                    5'h10:   rd_word = {presc_q[c], step_q[c]};
                    5'h14:   rd_word = {30'b0, ocw_q[c], fault_q[c]};
                    default: rd_word = '0;
                endcase
            end
        end
        wr_merged = (rd_word & ~bmask) | (pwdata & bmask);
        w1c       = pwdata & bmask;
        prdata    = (state_q == ST_DONE && !acc_err) ? rd_word : '0;
        pslverr   = (state_q == ST_DONE) && acc_err;
        pready    = (state_q != ST_ACCESS);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (psel && !penable) state_d = ST_ACCESS;
            ST_ACCESS: state_d = (psel && penable) ? ST_DONE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flt_s1_d  = ~fault_n;
        flt_s2_d  = flt_s1_q;
        ocw_s1_d  = ~overcurrent_n;
        ocw_s2_d  = ocw_s1_q;
        ctrl_en_d = ctrl_en_q;
        irq_en_d  = irq_en_q;
        fault_d   = fault_q;
        ocw_d     = ocw_q;
        en_out_d  = eff_en;
        irq_d     = |(irq_en_q & (fault_q | ocw_q));
        for (int c = 0; c < channels; c++) begin
            ctrl_dir_d[c] = ctrl_dir_q[c];
            target_d[c]   = target_q[c];
            step_d[c]     = step_q[c];
            presc_d[c]    = presc_q[c];
            pcnt_d[c]     = tick[c] ? '0 : pcnt_q[c] + 16'd1;
            ch_dir_d[c]   = (actual_q[c] == '0) ? ctrl_dir_q[c] : ch_dir_q[c];
            if (wr_commit && ch_hit[c]) begin
                case (offs)
                    5'h04: begin
                        ctrl_en_d[c]  = wr_merged[0];
                        ctrl_dir_d[c] = wr_merged[2:1];
                        irq_en_d[c]   = wr_merged[3];
                    end
                    5'h08: target_d[c] = wr_merged[duty_width-1:0];
                    5'h10: begin
                        step_d[c]  = wr_merged[15:0];
                        presc_d[c] = wr_merged[31:16];
                        pcnt_d[c]  = '0;
                    end
                    5'h14: begin
                        fault_d[c] = fault_q[c] & ~w1c[0];
                        ocw_d[c]   = ocw_q[c] & ~w1c[1];
                    end
                    default: ;
                endcase
            end
            // A pending event overrides a same-cycle clear.
            if (flt_s2_q[c]) fault_d[c] = 1'b1;
            if (ocw_s2_q[c]) ocw_d[c]   = 1'b1;

            actual_d[c] = actual_q[c];
            if (!eff_en[c]) begin
                actual_d[c] = '0;
            end else if (step_q[c] == '0) begin
                actual_d[c] = eff_tgt[c];
            end else if (tick[c]) begin
                if (actual_q[c] < eff_tgt[c])
                    actual_d[c] = (16'(eff_tgt[c] - actual_q[c]) > step_q[c])
                                  ? actual_q[c] + duty_width'(step_q[c]) : eff_tgt[c];
                else if (actual_q[c] > eff_tgt[c])
                    actual_d[c] = (16'(actual_q[c] - eff_tgt[c]) > step_q[c])
                                  ? actual_q[c] - duty_width'(step_q[c]) : eff_tgt[c];
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= ST_IDLE;
            ctrl_en_q <= '0;
            irq_en_q  <= '0;
            fault_q   <= '0;
            ocw_q     <= '0;
            flt_s1_q  <= '0;
            flt_s2_q  <= '0;
            ocw_s1_q  <= '0;
            ocw_s2_q  <= '0;
            en_out_q  <= '0;
            irq_q     <= 1'b0;
            for (int c = 0; c < channels; c++) begin
                ctrl_dir_q[c] <= DIR_NONE;
                ch_dir_q[c]   <= DIR_NONE;
                target_q[c]   <= '0;
                actual_q[c]   <= '0;
                step_q[c]     <= '0;
                presc_q[c]    <= '0;
                pcnt_q[c]     <= '0;
            end
        end else begin
            state_q   <= state_d;
            ctrl_en_q <= ctrl_en_d;
            irq_en_q  <= irq_en_d;
            fault_q   <= fault_d;
            ocw_q     <= ocw_d;
            flt_s1_q  <= flt_s1_d;
            flt_s2_q  <= flt_s2_d;
            ocw_s1_q  <= ocw_s1_d;
            ocw_s2_q  <= ocw_s2_d;
            en_out_q  <= en_out_d;
            irq_q     <= irq_d;
            for (int c = 0; c < channels; c++) begin
                ctrl_dir_q[c] <= ctrl_dir_d[c];
                ch_dir_q[c]   <= ch_dir_d[c];
                target_q[c]   <= target_d[c];
                actual_q[c]   <= actual_d[c];
                step_q[c]     <= step_d[c];
                presc_q[c]    <= presc_d[c];
                pcnt_q[c]     <= pcnt_d[c];
            end
        end
    end

    assign ch_enable = en_out_q;
    assign irq       = irq_q;

    always_comb begin
        for (int c = 0; c < channels; c++) begin
            ch_dir[2*c +: 2]                    = ch_dir_q[c];
            ch_duty[duty_width*c +: duty_width] = actual_q[c];
        end
    end
endmodule

// File: tb/tb_apb2_bldc_multi_ctrl.sv
// Directed bench for apb2_bldc_multi_ctrl: APB timing, ramping, reversal, faults, W1C, strobes and slave errors.
module tb_apb2_bldc_multi_ctrl;
    localparam int CH = 2;
    localparam int DW = 11;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]    paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [2:0]    pprot = '0;
    logic [31:0]   prdata;
    logic          pready, pslverr, irq;
    logic [3*CH-1:0] hall_values  = {3'b011, 3'b101};
    logic [3*CH-1:0] sector       = {3'b110, 3'b010};
    logic [2*CH-1:0] detected_dir = {2'b10, 2'b01};
    logic [CH-1:0]   hall_error   = 2'b01;
    logic [CH-1:0]   fault_n      = 2'b11;
    logic [CH-1:0]   overcurrent_n = 2'b11;
    logic [CH-1:0]   ch_enable;
    logic [2*CH-1:0] ch_dir;
    logic [DW*CH-1:0] ch_duty;

    int checks = 0;
    int errors = 0;
    int n;
    logic [10:0] exp_duty [9] = '{11'h180, 11'h100, 11'h080, 11'h000, 11'h000,
                                  11'h080, 11'h100, 11'h180, 11'h200};
    logic [1:0]  exp_dir  [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

    apb2_bldc_multi_ctrl #(.data_width(32), .addr_width(8), .channels(CH), .duty_width(DW)) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .hall_values(hall_values), .sector(sector),
        .detected_dir(detected_dir), .hall_error(hall_error), .fault_n(fault_n),
        .overcurrent_n(overcurrent_n), .ch_enable(ch_enable), .ch_dir(ch_dir),
        .ch_duty(ch_duty), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb(input string tag, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdata, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge pclk); #1;
        penable = 1'b1;
        check({tag, " pready access"}, 32'(pready), 32'd0);
        @(posedge pclk); #1;
        check({tag, " pready done"}, 32'(pready), 32'd1);
        rdata = prdata;
        err   = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic exp_err);
        logic [31:0] unused_rd;
        logic        e;
        apb(tag, 1'b1, a, d, s, unused_rd, e);
        check({tag, " pslverr"}, 32'(e), 32'(exp_err));
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] v;
        logic        e;
        apb(tag, 1'b0, a, 32'h0, 4'h0, v, e);
        check(tag, v, exp);
        check({tag, " pslverr"}, 32'(e), 32'(exp_err));
    endtask

    task automatic wait_duty(input int ch, input logic [10:0] v, input int max, output int cnt);
        bit hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < max) begin
            @(posedge pclk); #1;
            cnt++;
            hit = (ch_duty[ch*DW +: DW] == v);
        end
        if (!hit) cnt = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst pready", 32'(pready), 32'd1);
        check("rst pslverr", 32'(pslverr), 32'd0);
        check("rst prdata", prdata, 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        check("rst ch_enable", 32'(ch_enable), 32'd0);
        check("rst ch_duty", 32'(ch_duty), 32'd0);
        check("rst ch_dir", 32'(ch_dir), 32'd0);
        preset_n = 1'b1;

        rd("ch0 ctrl reset", 8'h04, 32'h0, 1'b0);
        rd("ch0 status", 8'h00, 32'h155, 1'b0);
        rd("ch1 status", 8'h20, 32'h0B3, 1'b0);
        rd("ch0 ramp reset", 8'h10, 32'h0, 1'b0);

        // Byte strobes
        wr("ctrl strb1", 8'h04, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        rd("ctrl after strb1", 8'h04, 32'h0, 1'b0);
        wr("tgt strb0", 8'h08, 32'h0000_FFFF, 4'b0001, 1'b0);
        rd("tgt after strb0", 8'h08, 32'h0FF, 1'b0);
        wr("tgt strb1", 8'h08, 32'h0000_0500, 4'b0010, 1'b0);
        rd("tgt after strb1", 8'h08, 32'h5FF, 1'b0);

        // Channel 1 ramp with prescale 3
        wr("ch1 tgt", 8'h28, 32'h400, 4'hF, 1'b0);
        wr("ch1 ramp", 8'h30, 32'h0003_0100, 4'hF, 1'b0);
        rd("ch1 ramp rd", 8'h30, 32'h0003_0100, 1'b0);
        wr("ch1 ctrl", 8'h24, 32'h3, 4'hF, 1'b0);
        wait_duty(1, 11'h100, 40, n);
        check("ch1 reach 0x100", 32'(n != -1), 32'd1);
        wait_duty(1, 11'h200, 10, n);
        check("ch1 0x100->0x200 cycles", n, 32'd4);
        wait_duty(1, 11'h300, 10, n);
        check("ch1 0x200->0x300 cycles", n, 32'd4);
        rd("ch1 status busy", 8'h20, 32'h8B3, 1'b0);
        wait_duty(1, 11'h400, 10, n);
        check("ch1 reach 0x400", 32'(n != -1), 32'd1);
        rd("ch1 status idle", 8'h20, 32'h0B3, 1'b0);
        rd("ch1 actual", 8'h2C, 32'h400, 1'b0);
        check("ch1 enable", 32'(ch_enable[1]), 32'd1);
        check("ch1 dir", 32'(ch_dir[3:2]), 32'd1);

        // Channel 0 reversal
        wr("ch0 tgt", 8'h08, 32'h200, 4'hF, 1'b0);
        wr("ch0 ramp", 8'h10, 32'h0000_0080, 4'hF, 1'b0);
        wr("ch0 ctrl cw", 8'h04, 32'hB, 4'hF, 1'b0);
        wait_duty(0, 11'h200, 20, n);
        check("ch0 reach 0x200", 32'(n != -1), 32'd1);
        check("ch0 dir cw", 32'(ch_dir[1:0]), 32'd1);
        wr("ch0 ctrl ccw", 8'h04, 32'hD, 4'hF, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge pclk); #1;
            check($sformatf("rev duty[%0d]", i), 32'(ch_duty[DW-1:0]), 32'(exp_duty[i]));
            check($sformatf("rev dir[%0d]", i), 32'(ch_dir[1:0]), 32'(exp_dir[i]));
        end

        // Fault on channel 0
        @(posedge pclk); #1;
        fault_n[0] = 1'b0;
        @(posedge pclk); #1;
        fault_n[0] = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
        check("fault ch_enable0", 32'(ch_enable[0]), 32'd0);
        check("fault duty0", 32'(ch_duty[DW-1:0]), 32'd0);
        check("fault irq", 32'(irq), 32'd1);
        check("fault ch_enable1", 32'(ch_enable[1]), 32'd1);
        rd("ch0 flags", 8'h14, 32'h1, 1'b0);
        wr("ctrl while sticky", 8'h04, 32'hD, 4'hF, 1'b0);
        rd("ctrl stored", 8'h04, 32'hD, 1'b0);
        check("sticky holds enable", 32'(ch_enable[0]), 32'd0);
        wr("ch0 w1c", 8'h14, 32'h1, 4'hF, 1'b0);
        repeat (2) @(posedge pclk);
        #1;
        check("clear ch_enable0", 32'(ch_enable[0]), 32'd1);
        check("clear irq", 32'(irq), 32'd0);
        rd("ch0 flags cleared", 8'h14, 32'h0, 1'b0);
        wait_duty(0, 11'h200, 20, n);
        check("ch0 re-ramp", 32'(n != -1), 32'd1);

        // Overcurrent on channel 1, irq not enabled there
        @(posedge pclk); #1;
        overcurrent_n[1] = 1'b0;
        @(posedge pclk); #1;
        overcurrent_n[1] = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
        check("ocw irq masked", 32'(irq), 32'd0);
        check("ocw keeps enable", 32'(ch_enable[1]), 32'd1);
        rd("ch1 flags", 8'h34, 32'h2, 1'b0);
        wr("ch1 w1c wrong strb", 8'h34, 32'h2, 4'b0010, 1'b0);
        rd("ch1 flags kept", 8'h34, 32'h2, 1'b0);
        wr("ch1 w1c", 8'h34, 32'h2, 4'hF, 1'b0);
        rd("ch1 flags cleared", 8'h34, 32'h0, 1'b0);

        // Slave errors
        wr("err wr actual", 8'h0C, 32'h123, 4'hF, 1'b1);
        wr("err wr status", 8'h00, 32'h0, 4'hF, 1'b1);
        wr("err wr 0x18", 8'h18, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wr("err wr ch2", 8'h44, 32'h0, 4'hF, 1'b1);
        wr("err wr unaligned", 8'h05, 32'h0, 4'hF, 1'b1);
        rd("err rd ch2", 8'h48, 32'h0, 1'b1);
        rd("after err ctrl0", 8'h04, 32'hD, 1'b0);
        rd("after err actual0", 8'h0C, 32'h200, 1'b0);
        rd("after err tgt0", 8'h08, 32'h200, 1'b0);
        rd("after err ctrl1", 8'h24, 32'h3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb2_bldc_multi_ctrl.md
Name: apb2_bldc_multi_ctrl

Overview:
APB2 slave register block controlling and monitoring up to `channels` BLDC motor channels from a single bus peripheral. It is the multi-channel successor to the single-channel BLDC APB peripheral. It adds per-channel duty slew-rate ramping, fault/overcurrent sticky latches with write-1-to-clear, byte strobes, pslverr decoding and an interrupt output. It sits between the APB2 bridge and the per-channel commutation drivers, which consume ch_enable/ch_dir/ch_duty.

Parameters:
- data_width, 32, APB data width; fixed at 32.
- addr_width, 8, APB address width; must satisfy channels*32 <= 2**addr_width.
- channels, 2, number of motor channels (1..8).
- duty_width, 11, width of duty target/actual registers (<=16).

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1=write.
- paddr  in  addr_width  byte address, word aligned.
- pwdata  in  32  write data.
- pstrb  in  4  byte enables.
- pprot  in  3  ignored.
- prdata  out  32  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- hall_values  in  3*channels  per-channel hall states {A,B,C}.
- sector  in  3*channels  per-channel sector from driver.
- detected_dir  in  2*channels  per-channel detected direction.
- hall_error  in  channels  per-channel hall error.
- fault_n  in  channels  driver fault, active low, asynchronous.
- overcurrent_n  in  channels  overcurrent warning, active low, asynchronous.
- ch_enable  out  channels  channel enable to driver.
- ch_dir  out  2*channels  applied direction (rotation_direction_t encoding).
- ch_duty  out  duty_width*channels  ramped duty.
- irq  out  1  OR of enabled sticky flags.

Behaviour:
- Reset (async): pready=1, pslverr=0, prdata=0, irq=0. All ch_enable/ch_duty=0, ch_dir=DIR_NONE. All registers 0, sticky flags 0, synchronisers 0.
- Address map, channel c base = c*0x20:
  - +0x00 STATUS RO: [2:0] hall, [5:3] sector, [7:6] detected_dir, [8] hall_error, [9] fault_sticky, [10] ocw_sticky, [11] ramp_busy (actual != target), others 0.
  - +0x04 CONTROL RW: [0] enable, [2:1] dir request, [3] irq_en.
  - +0x08 DUTY_TARGET RW: [duty_width-1:0].
  - +0x0C DUTY_ACTUAL RO.
  - +0x10 RAMP RW: [15:0] step, [31:16] prescale.
  - +0x14 FLAGS W1C: bit0 clears fault_sticky, bit1 clears ocw_sticky; reads {30'b0, ocw_sticky, fault_sticky}.
- APB FSM: IDLE -> ACCESS when psel & !penable. ACCESS -> DONE next cycle with pready=0. DONE drives pready=1 with prdata/pslverr valid for one cycle, commits any write, then returns to IDLE. Transfer = setup + 2 access cycles. pready is held 0 in ACCESS, 1 otherwise.
- If psel or penable drops in ACCESS, abort to IDLE with no commit.
- pslverr=1 in DONE when any of the following holds; no register changes on error:
  - address is unmapped (offset >= 0x18 or channel >= channels);
  - address is unaligned;
  - the transfer writes a RO register.
- Writes honour pstrb per byte. Unused/out-of-width bits read 0. prdata=0 outside DONE and on error.
- Fault inputs: 2-flop synchronised. A synced fault sets fault_sticky; synced ocw sets ocw_sticky. Set wins over a simultaneous W1C clear.
- Effective enable = CONTROL.enable & !fault_sticky. Writing enable=1 while sticky stores the bit but ch_enable stays 0 until the flag is cleared.
- irq = OR over channels of irq_en & (fault_sticky | ocw_sticky), registered (1-cycle latency).
- Ramp, per channel:
  - Prescale counter counts 0..prescale, then ticks and wraps. prescale=0 ticks every cycle.
  - On each tick, actual moves toward the effective target by min(step, |target-actual|). No over/underflow.
  - step=0 means actual = target on the next cycle.
  - Effective target = 0 when effective enable=0, or when dir request != ch_dir; otherwise DUTY_TARGET.
  - Disable (or fault) forces actual=0 on the next cycle, bypassing the ramp.
  - ch_dir loads the dir request only when actual==0. A reversal therefore ramps down, switches direction, then ramps up.
  - Writing RAMP restarts the prescale counter at 0.
- ch_duty = actual; ch_enable = registered effective enable.
- Reset mid-transfer: FSM to IDLE immediately, no commit.

Test Plan:
- Reset then read ch0 CONTROL at 0x04 -> 3-cycle transfer, prdata=0, pslverr=0; pready low exactly one cycle.
- Write ch1 DUTY_TARGET 0x400, RAMP {prescale=3, step=0x100}, CONTROL enable=1 dir=CW -> ch_duty steps 0x100, 0x200, 0x300, 0x400 every 4 cycles; STATUS[11] clears at 0x400.
- With ch0 running at duty 0x200 (step 0x80, prescale 0), write dir=CCW -> duty ramps 0x180, 0x100, 0x80, 0; ch_dir switches to CCW on the cycle after 0; duty then ramps back to 0x200.
- Pulse fault_n[0] low 1 cycle with irq_en=1 -> ch_enable[0]=0 and ch_duty=0 within 4 cycles, fault_sticky=1, irq=1. Writing FLAGS=0x1 clears both, and ch_enable resumes.
- Write to 0x0C, to 0x18, to channel index >= channels, and with paddr=0x05 -> pslverr=1 each time, registers unchanged.
- Write CONTROL with pwdata=0xFFFFFFFF, pstrb=0b0010 -> enable/dir/irq_en stay 0.
